// File: rtl/soml_stbc_encoder_if.sv
// SOML STBC encoder word/sample handshake bundle.
// master drives words and accepts samples; slave is the encoder side.
interface soml_stbc_encoder_if #(
  parameter int N = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [11:0]         signal_in_12bit;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] X_out_r;
  logic signed [N-1:0] X_out_i;
  logic                out_slot;
  logic [1:0]          out_ant;
  logic                out_last;

  modport master (
    output in_valid, signal_in_12bit, out_ready,
    input  in_ready, out_valid, X_out_r, X_out_i,
    input  out_slot, out_ant, out_last
  );

  modport slave (
    input  in_valid, signal_in_12bit, out_ready,
    output in_ready, out_valid, X_out_r, X_out_i,
    output out_slot, out_ant, out_last
  );
endinterface

// File: rtl/soml_stbc_encoder.sv
// SOML space-time encoder: 12-bit word -> 4x2 Alamouti codeword, 8 beats.
// SOML_ENC_UNIT_POWER_EN scales levels by round(2^Q/sqrt(10)).
module soml_stbc_encoder #(
  parameter int Q = 22,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  soml_stbc_encoder_if.slave   bus,
  output logic                 busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

`ifdef SOML_ENC_UNIT_POWER_EN
  localparam logic signed [N-1:0] K =
    N'($rtoi((2.0 ** Q) / $sqrt(10.0) + 0.5));
`endif

  logic [1:0]          state;
  logic [2:0]          beat;
  logic [11:0]         word;
  logic signed [N-1:0] bank_r [8];
  logic signed [N-1:0] bank_i [8];

  logic signed [3:0]   s1r, s1i, s2r, s2i;
  logic signed [3:0]   a1, b1, a2, b2;
  logic [1:0]          p0, p1;
  logic signed [3:0]   lv_r [8];
  logic signed [3:0]   lv_i [8];

  function automatic logic signed [3:0] gray(input logic [1:0] p);
    logic signed [3:0] v;
    case (p)
      2'b00:   v = -4'sd3;
      2'b01:   v = -4'sd1;
      2'b11:   v = 4'sd1;
      default: v = 4'sd3;
    endcase
    return v;
  endfunction

  function automatic logic signed [N-1:0] scale(
    input logic signed [3:0] l
  );
    logic signed [N-1:0] ext;
    ext = {{(N-4){l[3]}}, l};
`ifdef SOML_ENC_UNIT_POWER_EN
    return N'(ext * K);
`else
    return ext <<< Q;
`endif
  endfunction

  always_comb begin
    s1r = gray(word[7:6]);
    s1i = gray(word[5:4]);
    s2r = gray(word[3:2]);
    s2i = gray(word[1:0]);
    // j^r rotation by swap/negate only
    case (word[9:8])
      2'd0: begin a1 = s1r;  b1 = s1i;  a2 = s2r;  b2 = s2i;  end
      2'd1: begin a1 = -s1i; b1 = s1r;  a2 = -s2i; b2 = s2r;  end
      2'd2: begin a1 = -s1r; b1 = -s1i; a2 = -s2r; b2 = -s2i; end
      default: begin
        a1 = s1i; b1 = -s1r; a2 = s2i; b2 = -s2r;
      end
    endcase
    case (word[11:10])
      2'b00:   begin p0 = 2'd0; p1 = 2'd1; end
      2'b01:   begin p0 = 2'd2; p1 = 2'd3; end
      2'b10:   begin p0 = 2'd0; p1 = 2'd2; end
      default: begin p0 = 2'd1; p1 = 2'd3; end
    endcase
    for (int b = 0; b < 8; b++) begin
      lv_r[b] = '0;
      lv_i[b] = '0;
      if (b < 4) begin
        if (2'(b) == p0) begin
          lv_r[b] = a1; lv_i[b] = b1;
        end else if (2'(b) == p1) begin
          lv_r[b] = a2; lv_i[b] = b2;
        end
      end else begin
        if (2'(b - 4) == p0) begin
          lv_r[b] = -a2; lv_i[b] = b2;
        end else if (2'(b - 4) == p1) begin
          lv_r[b] = a1;  lv_i[b] = -b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      word  <= '0;
      for (int b = 0; b < 8; b++) begin
        bank_r[b] <= '0;
        bank_i[b] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            word  <= bus.signal_in_12bit;
            state <= LOAD;
          end
        end
        LOAD: begin
          for (int b = 0; b < 8; b++) begin
            bank_r[b] <= scale(lv_r[b]);
            bank_i[b] <= scale(lv_i[b]);
          end
          beat  <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (bus.out_ready) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == STREAM);
    busy          = (state != IDLE);
    bus.X_out_r   = '0;
    bus.X_out_i   = '0;
    bus.out_slot  = 1'b0;
    bus.out_ant   = 2'd0;
    bus.out_last  = 1'b0;
    if (state == STREAM) begin
      bus.X_out_r  = bank_r[beat];
      bus.X_out_i  = bank_i[beat];
      bus.out_slot = beat[2];
      bus.out_ant  = beat[1:0];
      bus.out_last = (beat == 3'd7);
    end
  end

endmodule

// File: tb/tb_soml_stbc_encoder.sv
// Scoreboard bench for soml_stbc_encoder: random words vs. complex-arithmetic model.
// Directed words, backpressure, mid-word reset and latency are covered too.
module tb_soml_stbc_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 0;

`ifdef SOML_ENC_UNIT_POWER_EN
  localparam int SCALE = 1326355;
  localparam logic [31:0] P3 = 32'd3979065;
  localparam logic [31:0] P1 = 32'd1326355;
`else
  localparam int SCALE = 1 << 22;
  localparam logic [31:0] P3 = 32'h00C00000;
  localparam logic [31:0] P1 = 32'h00400000;
`endif
  localparam logic [31:0] M3 = -P3;

  typedef struct {
    logic [31:0] r;
    logic [31:0] i;
    int          b;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cap_r [8];
  logic [31:0] cap_i [8];

  soml_stbc_encoder_if #(.N(32)) bus ();

  soml_stbc_encoder #(.Q(22), .N(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: Gray levels, j^r by repeated quarter turns, Alamouti matrix
  function automatic void push_word(input logic [11:0] w);
    int lv[4]  = '{-3, -1, 3, 1};
    int pr0[4] = '{0, 2, 0, 1};
    int pr1[4] = '{1, 3, 2, 3};
    int a1, b1, a2, b2, t, p0, p1;
    int xr[8];
    int xi[8];
    exp_t e;
    a1 = lv[w[7:6]]; b1 = lv[w[5:4]];
    a2 = lv[w[3:2]]; b2 = lv[w[1:0]];
    for (int k = 0; k < int'(w[9:8]); k++) begin
      t = a1; a1 = -b1; b1 = t;
      t = a2; a2 = -b2; b2 = t;
    end
    p0 = pr0[w[11:10]];
    p1 = pr1[w[11:10]];
    for (int b = 0; b < 8; b++) begin
      xr[b] = 0; xi[b] = 0;
    end
    xr[p0] = a1;      xi[p0] = b1;
    xr[p1] = a2;      xi[p1] = b2;
    xr[4 + p0] = -a2; xi[4 + p0] = b2;
    xr[4 + p1] = a1;  xi[4 + p1] = -b1;
    for (int b = 0; b < 8; b++) begin
      e.r = 32'(xr[b] * SCALE);
      e.i = 32'(xi[b] * SCALE);
      e.b = b;
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      push_word(bus.signal_in_12bit);
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.out_ready = 1'b1;
    else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 9) < 7);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      chk("in_ready_low_while_streaming", bus.in_ready, 1'b0);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          cap_r[{bus.out_slot, bus.out_ant}] = bus.X_out_r;
          cap_i[{bus.out_slot, bus.out_ant}] = bus.X_out_i;
          chk($sformatf("beat%0d", e.b),
              {bus.X_out_r, bus.X_out_i, bus.out_slot, bus.out_ant,
               bus.out_last},
              {e.r, e.i, (e.b >= 4), 2'(e.b % 4), (e.b == 7)});
        end
      end
    end
  end

  task automatic send(input logic [11:0] w);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.signal_in_12bit = w;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", 1'b1, 1'b0);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.signal_in_12bit = 12'($urandom);
    @(negedge clk);
    chk("load_cycle", {bus.out_valid, busy}, 2'b01);
    @(negedge clk);
    chk("first_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] hr, hi;
    int n;
    bus.in_valid = 1'b0;
    bus.signal_in_12bit = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_state",
        {bus.in_ready, bus.out_valid, busy, bus.X_out_r, bus.X_out_i,
         bus.out_slot, bus.out_ant, bus.out_last},
        {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 2'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T1
    send(12'h0A0);
    drain();
    chk("t1_b0", {cap_r[0], cap_i[0]}, {P3, P3});
    chk("t1_b1", {cap_r[1], cap_i[1]}, {M3, M3});
    chk("t1_b2b3", {cap_r[2], cap_i[2], cap_r[3], cap_i[3]}, 128'd0);
    chk("t1_b4", {cap_r[4], cap_i[4]}, {P3, M3});
    chk("t1_b5", {cap_r[5], cap_i[5]}, {P3, M3});
    chk("t1_b6b7", {cap_r[6], cap_i[6], cap_r[7], cap_i[7]}, 128'd0);

    // T2
    send(12'h1A0);
    drain();
    chk("t2_b0", {cap_r[0], cap_i[0]}, {M3, P3});

    // T3
    send(12'h4F5);
    drain();
    chk("t3_b2", {cap_r[2], cap_i[2]}, {P1, P1});
    chk("t3_ant01_zero", {cap_r[0], cap_i[0], cap_r[1], cap_i[1]}, 128'd0);

    // T4: stall b3 for three cycles
    rdy_mode = 2;
    bus.out_ready = 1'b1;
    send(12'($urandom));
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(bus.out_valid && !bus.out_slot && bus.out_ant == 2'd3)
               && n < 50);
    if (n >= 50) chk("t4_find_b3", 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    hr = bus.X_out_r;
    hi = bus.X_out_i;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold", {bus.out_valid, bus.out_slot, bus.out_ant,
                      bus.X_out_r, bus.X_out_i, bus.in_ready},
          {1'b1, 1'b0, 2'd3, hr, hi, 1'b0});
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();
    rdy_mode = 0;

    // T5: reset while b4 is presented
    send(12'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (exp_q.size() != 4 && n < 50);
    rst = 1'b1;
    #1;
    chk("t5_reset_outputs",
        {bus.in_ready, bus.out_valid, busy, bus.X_out_r, bus.X_out_i,
         bus.out_last},
        {1'b1, 1'b0, 1'b0, 64'd0, 1'b0});
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(12'h0A0);
    drain();
    chk("t5_after_b0", {cap_r[0], cap_i[0]}, {P3, P3});
    chk("t5_after_b4", {cap_r[4], cap_i[4]}, {P3, M3});

    // Random words under random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) send(12'($urandom));
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
